mem_access_seq: RTL

//  Memory-transaction sequencer for the SLC-3 datapath. Accepts one read or write

---
 rtl/mem_access_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Sequences one memory read or write for the SLC-3 datapath. A request is
// accepted in IDLE, the MAR is loaded, and the SRAM is accessed for a fixed
// number of wait states. For a read, the MDR then captures the SRAM data. For
// a write, the SRAM data is held for one more cycle. A single-cycle done pulse
// ends the transaction. The block has no data path. Address and data pass
// through the external MAR/MDR registers.
//
// Parameters
//   WAIT_CYCLES  number of cycles in ACCESS with CE plus OE or WE asserted
//                (legal range 1..15)
//
// Ports
//   Clk        in   system clock, rising-edge active
//   Reset      in   asynchronous, active-high reset to IDLE
//   req        in   start request, only looked at in IDLE
//   we         in   1 = write, 0 = read; captured together with req
//   ld_mar     out  MAR load strobe (address taken from bus)
//   ld_mdr     out  MDR load strobe (read data taken from SRAM)
//   mio_en     out  MDR input mux select: 1 = SRAM data, 0 = bus
//   mem_ce_n   out  SRAM chip enable, active-low
//   mem_oe_n   out  SRAM output enable, active-low
//   mem_we_n   out  SRAM write enable, active-low
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a transaction completes
//
// All outputs are decoded from registered state only. There is no
// combinational path from req/we to any output.
// -----------------------------------------------------------------------------
module mem_access_seq #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic req,
   input  logic we,
   output logic ld_mar,
   output logic ld_mdr,
   output logic mio_en,
   output logic mem_ce_n,
   output logic mem_oe_n,
   output logic mem_we_n,
   output logic busy,
   output logic done
);

   // ---------------------------------------------------------------------
   // Parameter legality: the wait counter is 4 bits wide
   // ---------------------------------------------------------------------
   if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
      $error("mem_access_seq: WAIT_CYCLES=%0d outside legal range 1..15",
             WAIT_CYCLES);
   end

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ACCESS  = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic       we_q;
   logic       we_q_nx;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         we_q  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         we_q  <= we_q_nx;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      we_q_nx  = we_q;

      case (state)
         IDLE: begin
            // The transaction type is latched only here. A later change on
            // we does not affect a transaction that is already running.
            if (req) begin
               state_nx = SETUP;
               we_q_nx  = we;
            end
         end

         SETUP: begin
            cnt_nx   = CNT_LOAD;
            state_nx = ACCESS;
         end

         ACCESS: begin
            // The counter is loaded with WAIT_CYCLES-1 and counts down to 0,
            // so ACCESS lasts exactly WAIT_CYCLES cycles.
            if (cnt != '0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               state_nx = CAPTURE;
            end
         end

         CAPTURE: begin
            state_nx = DONE;
         end

         DONE: begin
            // Always return through IDLE. A continuously held req therefore
            // leaves one idle cycle between transactions.
            state_nx = IDLE;
         end

         default: begin
            // Recover from an illegal encoding on the next cycle.
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode (Moore: state and we_q only)
   // ---------------------------------------------------------------------
   always_comb begin
      ld_mar   = 1'b0;
      ld_mdr   = 1'b0;
      mio_en   = 1'b0;
      mem_ce_n = 1'b1;
      mem_oe_n = 1'b1;
      mem_we_n = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;

      case (state)
         IDLE: begin
            // all outputs inactive
         end

         SETUP: begin
            busy   = 1'b1;
            ld_mar = 1'b1;
         end

         ACCESS: begin
            busy     = 1'b1;
            mem_ce_n = 1'b0;
            if (we_q) begin
               mem_we_n = 1'b0;
            end else begin
               mem_oe_n = 1'b0;
               mio_en   = 1'b1;
            end
         end

         CAPTURE: begin
            busy     = 1'b1;
            mem_ce_n = 1'b0;
            // A read keeps OE low while the MDR captures the SRAM data.
            // A write releases WE but keeps CE low, so the data is held.
            if (!we_q) begin
               mem_oe_n = 1'b0;
               mio_en   = 1'b1;
               ld_mdr   = 1'b1;
            end
         end

         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end

         default: begin
            // illegal encoding: outputs stay inactive
         end
      endcase
   end

endmodule
